serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes diff = a - b - bin, LSB first, one bit per clock, through a single full-subtractor cell.
- It is the inverse operation of the team's combinational ripple-carry adder. It is used to undo or cross-check adder results in area-constrained datapaths.
- Start/busy/done handshake. Operands are captured at start, so the caller may change them immediately afterwards.

Parameters:
- WIDTH, 4, operand and result width in bits. WIDTH must be at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- bin  input  1  borrow-in; captured when start is accepted
- busy  output  1  high while in SHIFT or DONE
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  registered difference
- borrow_out  output  1  registered final borrow

Behaviour:
- Reset: one clock, single domain. rst_n is sampled on the rising edge of clk; low forces a synchronous reset.
  - State goes to IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge where start=1, latch a into sa, b into sb, bin into br; clear the counter and the partial result; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one bit per edge:
  - d = sa[0] ^ sb[0] ^ br
  - nb = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)
  - Shift d into the MSB of the partial result, shifting right. Shift sa and sb right. br <= nb. Counter increments.
  - On the edge that processes bit WIDTH-1: load diff with the completed result and borrow_out with nb; go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge goes unconditionally to IDLE.
- Latency: start is sampled at edge E0, bits are processed at E1..E_WIDTH, and done is high in the cycle following E_WIDTH. Total: WIDTH+1 edges from start sample to return to IDLE.
- Back-to-back: a start held high continuously is accepted again on the first IDLE edge. Maximum throughput is one result per WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored and not queued. The in-flight operation is unaffected.
- Changes on a, b or bin after acceptance have no effect on the current result.
- Output holding: diff and borrow_out keep their value from the last completion until the next completion or reset. They do not change during SHIFT.
- Arithmetic: modulo 2^WIDTH. borrow_out=1 exactly when a < b + bin, evaluated as unsigned integers.
- Consistency: for every input combination, adding diff + b + bin with the ripple-carry adder returns a.
- Reset mid-operation (rst_n=0 in SHIFT or DONE): abort immediately. No done pulse; outputs go to 0; state goes to IDLE.
- rst_n=0 together with start=1: reset wins; start is not accepted.

Test Plan:
- Reset, then a=0000 b=0000 bin=0 -> done pulse after 4 bit-edges, diff=0000 borrow_out=0; busy high for 5 cycles.
- a=0101 b=0011 bin=0 -> diff=0010 borrow_out=0. a=1010 b=0101 bin=1 -> diff=0100 borrow_out=0.
- a=0001 b=1111 bin=0 -> diff=0010 borrow_out=1. a=0000 b=0000 bin=1 -> diff=1111 borrow_out=1.
- Hold start=1 for 12 cycles with a/b changing every cycle -> exactly two operations, using the operands present at the two accepting edges. diff stays stable between the done pulses.
- Assert rst_n=0 in the 2nd SHIFT cycle -> no done pulse, all outputs 0. The next start completes correctly.
- Exhaustive sweep over all 512 combinations of a, b, bin for WIDTH=4 -> diff + b + bin through the ripple-carry adder equals a. borrow_out matches the reference model (a < b + bin).

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b-bin, LSB first; ports clk, rst_n, start, a, b, bin -> busy, done, diff, borrow_out
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb, acc, acc_nx;
  logic [CW-1:0] cnt;
  logic br, d, nb, last;
  always_comb begin
    d = sa[0] ^ sb[0] ^ br;
    nb = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    acc_nx = {d, acc[WIDTH-1:1]};
    last = cnt == CW'(WIDTH - 1);
    state_nx = state == IDLE ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    busy = state == SHIFT || state == DONE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      acc <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      borrow_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        sa <= a;
        sb <= b;
        br <= bin;
        cnt <= '0;
        acc <= '0;
      end else if (state == SHIFT) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        br <= nb;
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          diff <= acc_nx;
          borrow_out <= nb;
        end
      end
    end
  end
endmodule
